draw_sequencer: RTL and testbench

Frame-level controller that drives the display handler's object-select mux and rasterises each selected rectangle into single-pixel VGA adapter writes. On every frame tick it erases every object's previous rectangle in background colour, pulses a one-cycle update strobe so game logic can move objects, then redraws every object at its new position and records that position for the next erase. Sits between the display handler (geometry source) and the VGA adapter (pixel sink).

---
 rtl/draw_pkg.sv | 32 +++
 rtl/draw_sequencer_rect_scan.sv | 39 +++
 rtl/draw_sequencer.sv | 179 +++++++++++++++++
 tb/tb_draw_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw sequencer: FSM states,
// slot numbering, screen defaults and the per-slot history entry.
package draw_pkg;

    localparam int         DEFAULT_NUM_SLOTS = 6;
    localparam int         DEFAULT_SCREEN_W  = 160;
    localparam int         DEFAULT_SCREEN_H  = 120;
    localparam logic [2:0] DEFAULT_BG_COLOUR = 3'b000;

    localparam logic [3:0] SLOT_PLAYER = 4'd1;
    localparam logic [3:0] SLOT_ENEMY1 = 4'd2;
    localparam logic [3:0] SLOT_ENEMY2 = 4'd3;
    localparam logic [3:0] SLOT_ENEMY3 = 4'd4;
    localparam logic [3:0] SLOT_ENEMY4 = 4'd5;
    localparam logic [3:0] SLOT_BULLET = 4'd6;

    typedef enum logic [2:0] {
        IDLE, E_LOAD, E_PIX, UPDATE, SETTLE, D_LOAD, D_PIX, DONE
    } seq_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
    } hist_entry_t;

    function automatic logic isEmpty(input hist_entry_t e);
        return (e.w == 5'd0) || (e.h == 5'd0);
    endfunction

endpackage

// File: rtl/draw_sequencer_rect_scan.sv
// Raster counter for one rectangle: px runs fastest, py steps at each row end.
// Shared by the erase and redraw phases of draw_sequencer.
module rect_scan (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    input  logic [4:0] width,
    input  logic [4:0] height,
    output logic [4:0] px,
    output logic [4:0] py,
    output logic       last
);

    logic lastCol;

    assign lastCol = (px == width - 5'd1);
    assign last    = lastCol && (py == height - 5'd1);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the synthesised logic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (start) begin
            px <= '0;
            py <= '0;
        end else if (step) begin
            if (lastCol) begin
                px <= '0;
                py <= py + 5'd1;
            end else begin
                px <= px + 5'd1;
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Per-frame erase / update / redraw controller: walks every object slot,
// rasterises its rectangle into single-pixel VGA writes and keeps a history.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int         NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int         SCREEN_W  = DEFAULT_SCREEN_W,
    parameter int         SCREEN_H  = DEFAULT_SCREEN_H,
    parameter logic [2:0] BG_COLOUR = DEFAULT_BG_COLOUR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [7:0] drawX,
    input  logic [6:0] drawY,
    input  logic [4:0] drawWidth,
    input  logic [4:0] drawHeight,
    input  logic [2:0] drawColour,
    output logic [3:0] control_signal,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       update_pulse,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    seq_state_t  state, stateNext;
    logic [3:0]  slot, slotNext;
    logic [IDX_W-1:0] slotIdx;
    logic        lastSlot;

    hist_entry_t history [NUM_SLOTS];
    hist_entry_t histEntry, drawEntry, work;
    logic [2:0]  workColour;

    logic [4:0]  px, py;
    logic        scanLast, scanning;
    logic [8:0]  xSum;
    logic [7:0]  ySum;
    logic        inScreen;

    assign slotIdx   = IDX_W'(slot - 4'd1);
    assign lastSlot  = (slot == 4'(NUM_SLOTS));
    assign histEntry = history[slotIdx];
    assign drawEntry = '{x: drawX, y: drawY, w: drawWidth, h: drawHeight};

    rect_scan u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  ((state == E_LOAD) || (state == D_LOAD)),
        .step   (scanning),
        .width  (work.w),
        .height (work.h),
        .px     (px),
        .py     (py),
        .last   (scanLast)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= stateNext;
            slot  <= slotNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        stateNext      = state;
        slotNext       = slot;
        control_signal = '0;
        update_pulse   = 1'b0;
        frame_done     = 1'b0;
        busy           = (state != IDLE);
        overrun        = frame_tick && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    stateNext = E_LOAD;
                    slotNext  = 4'd1;
                end
            end
            E_LOAD: begin
                control_signal = slot;
                if (!isEmpty(histEntry))  stateNext = E_PIX;
                else if (lastSlot)        stateNext = UPDATE;
                else                      slotNext  = slot + 4'd1;
            end
            E_PIX: begin
                control_signal = slot;
                if (scanLast) begin
                    if (lastSlot) begin
                        stateNext = UPDATE;
                    end else begin
                        stateNext = E_LOAD;
                        slotNext  = slot + 4'd1;
                    end
                end
            end
            UPDATE: begin
                update_pulse = 1'b1;
                stateNext    = SETTLE;
            end
            SETTLE: begin
                stateNext = D_LOAD;
                slotNext  = 4'd1;
            end
            D_LOAD: begin
                control_signal = slot;
                if (!isEmpty(drawEntry))  stateNext = D_PIX;
                else if (lastSlot)        stateNext = DONE;
                else                      slotNext  = slot + 4'd1;
            end
            D_PIX: begin
                control_signal = slot;
                if (scanLast) begin
                    if (lastSlot) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = D_LOAD;
                        slotNext  = slot + 4'd1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                stateNext  = IDLE;
                slotNext   = '0;
            end
        endcase
    end

    // NOTE: the history is a handful of flops and must read as empty after
    // reset so the first erase is a no-op, hence it is reset explicitly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            work       <= '0;
            workColour <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) history[i] <= '0;
        end else if (state == E_LOAD) begin
            work <= histEntry;
        end else if (state == D_LOAD) begin
            work             <= drawEntry;
            workColour       <= drawColour;
            history[slotIdx] <= drawEntry;
        end
    end

    // Widened sums so off-screen pixels are detected rather than wrapped.
    assign scanning = (state == E_PIX) || (state == D_PIX);
    assign xSum     = {1'b0, work.x} + 9'(px);
    assign ySum     = {1'b0, work.y} + 8'(py);
    assign inScreen = (xSum < 9'(SCREEN_W)) && (ySum < 8'(SCREEN_H));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else begin
            plot <= scanning && inScreen;
            if (scanning) begin
                vga_x      <= xSum[7:0];
                vga_y      <= ySum[6:0];
                vga_colour <= (state == E_PIX) ? BG_COLOUR : workColour;
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: directed frames plus random frames,
// compared against a rectangle-enumeration model of erase and redraw.
module tb_draw_sequencer;
    import draw_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] drawX;
    logic [6:0] drawY;
    logic [4:0] drawWidth, drawHeight;
    logic [2:0] drawColour;
    logic [3:0] control_signal;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, update_pulse, busy, frame_done, overrun;

    typedef struct { int x; int y; int w; int h; int c; } obj_t;
    typedef struct { int x; int y; int c; } pix_t;

    obj_t shown[1:6];
    obj_t pending[1:6];
    obj_t prev[1:6];
    pix_t expQ[$];

    int errors = 0;
    int checks = 0;

    draw_sequencer dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .drawX(drawX), .drawY(drawY), .drawWidth(drawWidth),
        .drawHeight(drawHeight), .drawColour(drawColour),
        .control_signal(control_signal), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .plot(plot), .update_pulse(update_pulse),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Display handler: combinational mux over the currently shown objects.
    always_comb begin
        drawX = '0; drawY = '0; drawWidth = '0; drawHeight = '0; drawColour = '0;
        for (int s = 1; s <= 6; s++) begin
            if (control_signal == 4'(s)) begin
                drawX      = 8'(shown[s].x);
                drawY      = 7'(shown[s].y);
                drawWidth  = 5'(shown[s].w);
                drawHeight = 5'(shown[s].h);
                drawColour = 3'(shown[s].c);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y, input int c);
        return 32'((x << 16) | (y << 8) | c);
    endfunction

    // Reference: every slot's rectangle, row by row, clipped to the screen.
    function automatic void add_rects(input obj_t o[1:6], input int forceColour);
        for (int s = 1; s <= 6; s++)
            if (o[s].w != 0 && o[s].h != 0)
                for (int r = 0; r < o[s].h; r++)
                    for (int c = 0; c < o[s].w; c++)
                        if (o[s].x + c < 160 && o[s].y + r < 120)
                            expQ.push_back('{o[s].x + c, o[s].y + r,
                                             (forceColour >= 0) ? forceColour : o[s].c});
    endfunction

    function automatic int phase_cost(input obj_t o[1:6]);
        int n = 0;
        for (int s = 1; s <= 6; s++)
            n += 1 + ((o[s].w != 0 && o[s].h != 0) ? o[s].w * o[s].h : 0);
        return n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, 32'(control_signal), 0);
        check({tag, "_vx"}, 32'(vga_x), 0);
        check({tag, "_vy"}, 32'(vga_y), 0);
        check({tag, "_col"}, 32'(vga_colour), 0);
        check({tag, "_plot"}, 32'(plot), 0);
        check({tag, "_upd"}, 32'(update_pulse), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    function automatic void clear_objs(output obj_t o[1:6]);
        for (int s = 1; s <= 6; s++) o[s] = '{0, 0, 0, 0, 0};
    endfunction

    // Runs one frame from a negedge in IDLE; optional overrun tick at
    // update+ovOffset, optional reset at cycle rstAt (aborts the frame).
    task automatic run_frame(input int ovOffset, input int rstAt);
        int nErase, eCost, dCost, k, updK, doneK, idx, lastCs;
        bit ovSet;
        int csE[$];
        int csD[$];
        expQ.delete();
        add_rects(prev, int'(DEFAULT_BG_COLOUR));
        nErase = expQ.size();
        add_rects(pending, -1);
        eCost = phase_cost(prev);
        dCost = phase_cost(pending);
        updK = 0; doneK = 0; idx = 0; lastCs = 0; ovSet = 0;
        frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        k = 1;
        while (k <= 2000) begin
            if (rstAt != 0 && k == rstAt) begin
                resetn = 1'b0;
                #1;
                check_reset_outputs("midreset");
                return;
            end
            if (plot) begin
                if (idx < expQ.size()) begin
                    check("plot_pixel", pk(vga_x, vga_y, vga_colour),
                          pk(expQ[idx].x, expQ[idx].y, expQ[idx].c));
                    check("plot_phase", 32'(updK != 0), 32'(idx >= nErase));
                end else begin
                    check("plot_overflow", idx, expQ.size() - 1);
                end
                idx++;
            end
            if (control_signal != 0 && int'(control_signal) != lastCs) begin
                if (updK == 0) csE.push_back(int'(control_signal));
                else           csD.push_back(int'(control_signal));
            end
            lastCs = int'(control_signal);
            if (update_pulse) begin
                check("update_once", updK, 0);
                updK = k;
                shown = pending;
            end
            if (ovOffset != 0 && updK != 0 && k == updK + ovOffset) begin
                frame_tick = 1'b1;
                #1;
                check("overrun_high", 32'(overrun), 1);
                ovSet = 1;
            end else if (ovSet && frame_tick) begin
                frame_tick = 1'b0;
                #1;
                check("overrun_low", 32'(overrun), 0);
            end
            if (frame_done) begin
                doneK = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        check("frame_done_seen", 32'(doneK != 0), 1);
        check("plot_total", idx, expQ.size());
        check("update_cycle", updK, 1 + eCost);
        check("done_cycle", doneK, updK + 2 + dCost);
        check("erase_slot_visits", csE.size(), 6);
        check("draw_slot_visits", csD.size(), 6);
        for (int i = 0; i < csE.size() && i < 6; i++) check("erase_slot_order", csE[i], i + 1);
        for (int i = 0; i < csD.size() && i < 6; i++) check("draw_slot_order", csD[i], i + 1);
        @(negedge clk);
        check("idle_after", 32'(busy), 0);
        @(negedge clk);
        check("idle_after2", 32'(busy), 0);
        prev = pending;
    endtask

    initial begin
        clear_objs(shown);
        clear_objs(pending);
        clear_objs(prev);

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        // First frame: nothing to erase, one 3x2 object
        pending[1] = '{10, 20, 3, 2, 2};
        shown = pending;
        run_frame(0, 0);

        // Object moves right by one
        pending[1] = '{11, 20, 3, 2, 2};
        run_frame(0, 0);

        // Bullet partly off the bottom-right corner
        pending[6] = '{158, 118, 4, 3, 5};
        run_frame(0, 0);

        // Overrun tick during the redraw of a 4x4 object
        pending[1] = '{20, 30, 4, 4, 3};
        pending[6] = '{0, 0, 0, 0, 0};
        run_frame(5, 0);

        // Reset during the erase scan of slot 1
        run_frame(0, 3);
        repeat (3) begin
            @(negedge clk);
            check("plot_in_reset", 32'(plot), 0);
        end
        resetn = 1'b1;
        clear_objs(prev);
        @(negedge clk);
        run_frame(0, 0);

        // All six slots as 1x1 objects, then moved
        for (int s = 1; s <= 6; s++) pending[s] = '{10 * s, 5 * s, 1, 1, s};
        run_frame(0, 0);
        for (int s = 1; s <= 6; s++) pending[s] = '{10 * s + 1, 5 * s + 2, 1, 1, 7 - s};
        run_frame(0, 0);

        // Random frames
        repeat (4) begin
            for (int s = 1; s <= 6; s++)
                pending[s] = '{int'($urandom_range(0, 165)), int'($urandom_range(0, 125)),
                               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                               int'($urandom_range(0, 7))};
            run_frame(0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
